neopixel_chain: RTL and testbench

- Parametrised single-wire driver for WS2812/SK6812-class LED chains. Successor to the fixed 7-pixel driver.
- Timing comes from parameters in clock cycles. Pixel width (RGB/RGBW) and chain length are parameters.
- The colour vector is snapshotted on start/busy/done handshake, then one frame is emitted followed by a latch gap.
- Sits between the register/bus-facing colour store and the LED data pin.

---
 rtl/neopixel_chain.sv | 151 +++++++++++++++
 tb/tb_neopixel_chain.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_chain.sv
// Single-wire WS2812/SK6812 chain driver: snapshots the colour vector, emits one frame, then a latch gap.
// Optional continuous refresh is enabled by defining NEOPIXEL_AUTO_REFRESH_EN.
module neopixel_chain #(
  parameter int NUM_PIXELS     = 7,
  parameter int BITS_PER_PIXEL = 32,
  parameter int T0H            = 20,
  parameter int T0L            = 43,
  parameter int T1H            = 40,
  parameter int T1L            = 23,
  parameter int T_RESET        = 14000
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [NUM_PIXELS*BITS_PER_PIXEL-1:0] color,
  input  logic                                 start,
`ifdef NEOPIXEL_AUTO_REFRESH_EN
  input  logic                                 auto_refresh,
`endif
  output logic                                 busy,
  output logic                                 done,
  output logic                                 one_wire
);

  localparam int TOTAL = NUM_PIXELS * BITS_PER_PIXEL;
  localparam int HMAX  = (T0H > T1H) ? T0H : T1H;
  localparam int LMAX  = (T0L > T1L) ? T0L : T1L;
  localparam int HLMAX = (HMAX > LMAX) ? HMAX : LMAX;
  localparam int TMAX  = (HLMAX > T_RESET) ? HLMAX : T_RESET;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [TW-1:0] T0H_LD = TW'(T0H - 1);
  localparam logic [TW-1:0] T0L_LD = TW'(T0L - 1);
  localparam logic [TW-1:0] T1H_LD = TW'(T1H - 1);
  localparam logic [TW-1:0] T1L_LD = TW'(T1L - 1);
  localparam logic [TW-1:0] TR_LD  = TW'(T_RESET - 1);
  localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);

  if (NUM_PIXELS < 1 || BITS_PER_PIXEL < 1 || T0H < 1 || T0L < 1 ||
      T1H < 1 || T1L < 1 || T_RESET < 1) begin : g_param_check
    $error("neopixel_chain: all size and timing parameters must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t           state, state_nx;
  logic [TOTAL-1:0] sr, sr_sh, ordered;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer, timer_nx;
  logic             capture, shift, finish, refresh;
  logic             one_wire_nx, busy_nx, done_nx;

`ifdef NEOPIXEL_AUTO_REFRESH_EN
  assign refresh = auto_refresh;
`else
  assign refresh = 1'b0;
`endif

  // Reorder so pixel 0 sits at the top: shifting left then yields pixel 0 MSB-first, then pixel 1, ...
  always_comb begin
    ordered = '0;
    for (int unsigned k = 0; k < NUM_PIXELS; k++)
      ordered[(NUM_PIXELS-1-k)*BITS_PER_PIXEL +: BITS_PER_PIXEL] =
        color[k*BITS_PER_PIXEL +: BITS_PER_PIXEL];
  end

  assign sr_sh = sr << 1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      if (capture) begin
        sr  <= ordered;
        cnt <= '0;
      end else if (shift) begin
        sr  <= sr_sh;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Timer holds remaining cycles minus one and is reloaded on every phase change.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    shift    = 1'b0;
    finish   = 1'b0;
    timer_nx = timer - TW'(1);
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (start) begin
          state_nx = HIGH;
          capture  = 1'b1;
          timer_nx = ordered[TOTAL-1] ? T1H_LD : T0H_LD;
        end
      end
      HIGH: if (timer == '0) begin
        state_nx = LOW;
        timer_nx = sr[TOTAL-1] ? T1L_LD : T0L_LD;
      end
      LOW: if (timer == '0) begin
        if (cnt == LAST) begin
          state_nx = LATCH;
          timer_nx = TR_LD;
        end else begin
          state_nx = HIGH;
          shift    = 1'b1;
          timer_nx = sr_sh[TOTAL-1] ? T1H_LD : T0H_LD;
        end
      end
      LATCH: if (timer == '0) begin
        finish = 1'b1;
        if (refresh) begin
          state_nx = HIGH;
          capture  = 1'b1;
          timer_nx = ordered[TOTAL-1] ? T1H_LD : T0H_LD;
        end else begin
          state_nx = IDLE;
          timer_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    one_wire_nx = (state_nx == HIGH);
    busy_nx     = (state_nx != IDLE);
    done_nx     = finish;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      one_wire <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      one_wire <= one_wire_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

endmodule

// File: tb/tb_neopixel_chain.sv
// Self-checking bench for neopixel_chain: per-frame waveforms compared against a bit-timing model.
// Define NEOPIXEL_AUTO_REFRESH_EN for both files to exercise the refresh scenario.
module tb_neopixel_chain;

  localparam int NP    = 2;
  localparam int BPP   = 24;
  localparam int NB    = NP * BPP;
  localparam int FRAME = 298;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic [NB-1:0] color   = '0;
  logic          busy, done, one_wire;
`ifdef NEOPIXEL_AUTO_REFRESH_EN
  logic          auto_refresh = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  neopixel_chain #(
    .NUM_PIXELS(NP), .BITS_PER_PIXEL(BPP),
    .T0H(2), .T0L(4), .T1H(4), .T1L(2), .T_RESET(10)
  ) dut (
    .clock(clock), .reset_n(reset_n), .color(color), .start(start),
`ifdef NEOPIXEL_AUTO_REFRESH_EN
    .auto_refresh(auto_refresh),
`endif
    .busy(busy), .done(done), .one_wire(one_wire)
  );

  always #5 clock = ~clock;

  function automatic logic [NB-1:0] rand_color();
    return {16'($urandom), $urandom};
  endfunction

  // Line level for each cycle after the start edge: pixel 0 first, MSB first, then a low latch gap.
  function automatic logic [FRAME-1:0] model_wave(input logic [NB-1:0] c);
    logic [FRAME-1:0] w;
    int t, hi, lo;
    logic b;
    w = '0;
    t = 0;
    for (int i = 0; i < NB; i++) begin
      b  = c[(i / BPP) * BPP + (BPP - 1 - i % BPP)];
      hi = b ? 4 : 2;
      lo = b ? 2 : 4;
      for (int k = 0; k < hi; k++) begin
        w[t] = 1'b1;
        t++;
      end
      t += lo;
    end
    return w;
  endfunction

  // Called at the negedge right after the start edge; returns at the negedge after the final edge.
  task automatic check_frame(input logic [NB-1:0] c, input int perturb_at,
                             input logic busy_end, input string name);
    logic [FRAME-1:0] exp_w, act_w, act_b, act_d;
    exp_w = model_wave(c);
    for (int t = 0; t < FRAME; t++) begin
      act_w[t] = one_wire;
      act_b[t] = busy;
      act_d[t] = done;
      if (perturb_at >= 0 && t == perturb_at) begin
        color = rand_color();
        start = 1'b1;
      end
      if (perturb_at >= 0 && t == perturb_at + 1) start = 1'b0;
      @(negedge clock);
    end
    vectors++;
    if (act_w !== exp_w) begin
      miscompares++;
      $display("FAIL %s wave got %h expected %h", name, act_w, exp_w);
    end
    vectors++;
    if (act_b !== {FRAME{1'b1}}) begin
      miscompares++;
      $display("FAIL %s busy_during got %h expected all ones", name, act_b);
    end
    vectors++;
    if (act_d[FRAME-1:1] !== '0) begin
      miscompares++;
      $display("FAIL %s done_early got %h expected zero", name, act_d);
    end
    vectors++;
    if ({done, busy, one_wire} !== {1'b1, busy_end, busy_end}) begin
      miscompares++;
      $display("FAIL %s frame_end done/busy/wire got %b%b%b expected 1%b%b",
               name, done, busy, one_wire, busy_end, busy_end);
    end
  endtask

  task automatic kick(input logic [NB-1:0] c);
    color = c;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if ({done, busy, one_wire} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s done/busy/wire got %b%b%b expected 000", name, done, busy, one_wire);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    color   = rand_color();
    repeat (3) @(negedge clock);
    check_idle("reset_held");
    reset_n = 1'b1;
    start   = 1'b0;
    @(negedge clock);
    check_idle("after_reset");
  endtask

  task automatic test_first_bit();
    kick(48'h000000_800000);
    check_frame(48'h000000_800000, -1, 1'b0, "first_bit");
    @(negedge clock);
    check_idle("done_one_cycle");
  endtask

  task automatic test_order();
    kick(48'hFFFFFF_000000);
    check_frame(48'hFFFFFF_000000, -1, 1'b0, "pixel_order");
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [NB-1:0] c;
    for (int n = 0; n < 3; n++) begin
      c = rand_color();
      kick(c);
      check_frame(c, -1, 1'b0, $sformatf("random%0d", n));
      repeat (n + 1) @(negedge clock);
    end
  endtask

  task automatic test_busy_ignore();
    logic [NB-1:0] c;
    logic seen_busy;
    c = rand_color();
    kick(c);
    check_frame(c, 100, 1'b0, "busy_ignore");
    seen_busy = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      seen_busy = seen_busy | busy | one_wire | done;
    end
    vectors++;
    if (seen_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL no_second_frame got activity %b expected 0", seen_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] c1, c2;
    c1 = rand_color();
    c2 = rand_color();
    color = c1;
    start = 1'b1;
    @(negedge clock);
    color = c2;
    check_frame(c1, -1, 1'b0, "b2b_first");
    @(negedge clock);
    check_frame(c2, -1, 1'b0, "b2b_second");
    start = 1'b0;
    @(negedge clock);
    check_idle("b2b_stop");
  endtask

  task automatic test_mid_reset();
    logic [NB-1:0] c;
    kick(rand_color());
    repeat (50) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_idle("mid_reset");
    reset_n = 1'b1;
    @(negedge clock);
    check_idle("mid_reset_release");
    c = rand_color();
    kick(c);
    check_frame(c, -1, 1'b0, "after_mid_reset");
    @(negedge clock);
  endtask

`ifdef NEOPIXEL_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    logic [NB-1:0] c1, c2;
    c1 = rand_color();
    c2 = rand_color();
    auto_refresh = 1'b1;
    kick(c1);
    color = c2;
    check_frame(c1, -1, 1'b1, "auto_first");
    auto_refresh = 1'b0;
    check_frame(c2, -1, 1'b0, "auto_second");
    @(negedge clock);
    check_idle("auto_stop");
  endtask
`endif

  initial begin
    @(negedge clock);
    test_reset();
    test_first_bit();
    test_order();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
`ifdef NEOPIXEL_AUTO_REFRESH_EN
    test_auto_refresh();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
